// File: rtl/ftoi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ftoi_pipe
// Purpose  : float32 -> signed/unsigned integer converter with selectable
//            rounding, saturation and NV/NX flags, behind a valid/ready
//            pipeline that carries a flag/address tag with each operation.
// Revision : 1.0 - initial release
// ============================================================================
module ftoi_pipe #(
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 5,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       adata,
    input  logic [2:0]        rm,
    input  logic              is_unsigned,
    input  logic              flag_in,
    input  logic [ADDR_W-1:0] address_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result,
    output logic              nv,
    output logic              nx,
    output logic              flag_out,
    output logic [ADDR_W-1:0] address_out
);

    // Working width holds the largest in-range magnitude plus the rounding carry.
    localparam int c_MW = (OUT_W + 2 > 25) ? OUT_W + 2 : 25;
    localparam logic [c_MW-1:0]  c_ONE      = c_MW'(1);
    localparam logic [c_MW-1:0]  c_SMAX     = (c_ONE << (OUT_W - 1)) - c_ONE;
    localparam logic [c_MW-1:0]  c_SNEG     = c_ONE << (OUT_W - 1);
    localparam logic [c_MW-1:0]  c_UMAX     = (c_ONE << OUT_W) - c_ONE;
    localparam logic [OUT_W-1:0] c_RES_SMAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] c_RES_SMIN = {1'b1, {(OUT_W - 1){1'b0}}};
    localparam logic [OUT_W-1:0] c_RES_UMAX = {OUT_W{1'b1}};
    localparam logic signed [9:0] c_EBIG    = 10'(OUT_W + 1);

    logic                w_en;
    logic                w_acc;
    logic                w_s;
    logic [7:0]          w_exp;
    logic [22:0]         w_man;
    logic [23:0]         w_sig;
    logic signed [9:0]   w_e;
    logic [9:0]          w_lsh;
    logic [4:0]          w_rsh;
    logic [47:0]         w_ext;
    logic [c_MW-1:0]     w_mag;
    logic [c_MW-1:0]     w_rmag;
    logic                w_g;
    logic                w_st;
    logic                w_inc;
    logic                w_legal;
    logic [OUT_W-1:0]    w_sat;
    logic [OUT_W-1:0]    w_res;
    logic                w_nv;
    logic                w_nx;

    logic [LAT-1:0]      r_valid;
    logic [OUT_W-1:0]    r_res  [LAT];
    logic                r_nv   [LAT];
    logic                r_nx   [LAT];
    logic                r_flag [LAT];
    logic [ADDR_W-1:0]   r_addr [LAT];

    assign w_s   = adata[31];
    assign w_exp = adata[30:23];
    assign w_man = adata[22:0];
    assign w_sig = {1'b1, w_man};
    assign w_e   = $signed({2'b00, w_exp}) - 10'sd127;
    assign w_lsh = 10'(w_e - 10'sd23);
    assign w_rsh = 5'(10'sd23 - w_e);

    // Right shift of {sig,0} leaves the guard bit and sticky bits below the integer part.
    always_comb begin
        w_mag = '0;
        w_g   = 1'b0;
        w_st  = 1'b0;
        w_ext = {w_sig, 24'b0} >> w_rsh;
        if (w_e >= 10'sd23) begin
            w_mag = c_MW'(w_sig) << w_lsh;
        end else if (w_e >= -10'sd1) begin
            w_mag = c_MW'(w_ext[47:24]);
            w_g   = w_ext[23];
            w_st  = |w_ext[22:0];
        end else begin
            w_st  = 1'b1;
        end
    end

    always_comb begin
        w_inc = 1'b0;
        case (rm)
            3'd0:    w_inc = w_g & (w_st | w_mag[0]);
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = w_s & (w_g | w_st);
            3'd3:    w_inc = ~w_s & (w_g | w_st);
            default: w_inc = w_g;
        endcase
    end

    assign w_rmag = w_mag + c_MW'(w_inc);

    always_comb begin
        w_legal = 1'b0;
        w_sat   = '0;
        if (is_unsigned) begin
            w_legal = (~w_s && (w_rmag <= c_UMAX)) || (w_rmag == '0);
            w_sat   = w_s ? '0 : c_RES_UMAX;
        end else begin
            w_legal = w_s ? (w_rmag <= c_SNEG) : (w_rmag <= c_SMAX);
            w_sat   = w_s ? c_RES_SMIN : c_RES_SMAX;
        end
    end

    always_comb begin
        w_res = '0;
        w_nv  = 1'b0;
        w_nx  = 1'b0;
        if (w_exp == 8'hFF) begin
            w_nv  = 1'b1;
            w_res = (w_man != '0) ? (is_unsigned ? c_RES_UMAX : c_RES_SMAX) : w_sat;
        end else if (w_exp == 8'h00) begin
            w_res = '0;
        end else if ((w_e >= c_EBIG) || !w_legal) begin
            w_nv  = 1'b1;
            w_res = w_sat;
        end else begin
            w_res = (!is_unsigned && w_s) ? OUT_W'(-w_rmag) : OUT_W'(w_rmag);
            w_nx  = w_g | w_st;
        end
    end

    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en & ~rst;
    assign w_acc    = in_valid & in_ready;

    // Every stage advances together; idle slots carry zeroed payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_res[i]  <= '0;
                r_nv[i]   <= 1'b0;
                r_nx[i]   <= 1'b0;
                r_flag[i] <= 1'b0;
                r_addr[i] <= '0;
            end
        end else if (w_en) begin
            r_valid[0] <= w_acc;
            r_res[0]   <= w_acc ? w_res : '0;
            r_nv[0]    <= w_acc & w_nv;
            r_nx[0]    <= w_acc & w_nx;
            r_flag[0]  <= w_acc & flag_in;
            r_addr[0]  <= w_acc ? address_in : '0;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_res[i]   <= r_res[i-1];
                r_nv[i]    <= r_nv[i-1];
                r_nx[i]    <= r_nx[i-1];
                r_flag[i]  <= r_flag[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign out_valid   = r_valid[LAT-1];
    assign result      = r_res[LAT-1];
    assign nv          = r_nv[LAT-1];
    assign nx          = r_nx[LAT-1];
    assign flag_out    = r_flag[LAT-1];
    assign address_out = r_addr[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_ftoi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftoi_pipe
// Purpose  : Self-checking bench for ftoi_pipe (32-bit/LAT=2 and 16-bit/LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ftoi_pipe;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_uns, a_flag, a_out_valid, a_out_ready;
    logic        a_nv, a_nx, a_flag_out;
    logic [31:0] a_adata, a_result;
    logic [2:0]  a_rm;
    logic [4:0]  a_addr, a_addr_out;

    logic        b_in_valid, b_in_ready, b_uns, b_flag, b_out_valid, b_out_ready;
    logic        b_nv, b_nx, b_flag_out;
    logic [31:0] b_adata;
    logic [15:0] b_result;
    logic [2:0]  b_rm;
    logic [4:0]  b_addr, b_addr_out;

    int vectors     = 0;
    int miscompares = 0;
    int tagc        = 0;

    typedef struct {
        logic [63:0] res;
        bit          nv;
        bit          nx;
        bit          flag;
        logic [4:0]  addr;
    } exp_t;

    ftoi_pipe #(.OUT_W(32), .ADDR_W(5), .LAT(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .adata(a_adata), .rm(a_rm), .is_unsigned(a_uns), .flag_in(a_flag),
        .address_in(a_addr), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .result(a_result), .nv(a_nv), .nx(a_nx), .flag_out(a_flag_out),
        .address_out(a_addr_out)
    );

    ftoi_pipe #(.OUT_W(16), .ADDR_W(5), .LAT(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .adata(b_adata), .rm(b_rm), .is_unsigned(b_uns), .flag_in(b_flag),
        .address_in(b_addr), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result), .nv(b_nv), .nx(b_nx), .flag_out(b_flag_out),
        .address_out(b_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact real-valued magnitude, rounded with floor/fraction rules.
    function automatic void model(input logic [31:0] a, input logic [2:0] m, input bit u,
                                  input int w, output logic [63:0] res, output bit nv,
                                  output bit nx);
        bit          s;
        int          ex, mn;
        real         x, fl, fr, r;
        bit          ok;
        longint      ri;
        logic [63:0] mask;
        s    = a[31];
        ex   = int'(a[30:23]);
        mn   = int'(a[22:0]);
        mask = (64'd1 << w) - 64'd1;
        res  = '0;
        nv   = 1'b0;
        nx   = 1'b0;
        if (ex == 0) return;
        if (ex == 255 && mn != 0) begin
            nv  = 1'b1;
            res = u ? mask : (mask >> 1);
            return;
        end
        x  = (ex == 255) ? 2.0 ** 80 : (8388608.0 + mn) * 2.0 ** (ex - 150);
        fl = $floor(x);
        fr = x - fl;
        case (m)
            3'd0:    r = (fr > 0.5 || (fr == 0.5 && (fl / 2.0 != $floor(fl / 2.0)))) ? fl + 1.0 : fl;
            3'd1:    r = fl;
            3'd2:    r = (s && fr > 0.0) ? fl + 1.0 : fl;
            3'd3:    r = (!s && fr > 0.0) ? fl + 1.0 : fl;
            default: r = (fr >= 0.5) ? fl + 1.0 : fl;
        endcase
        if (u) ok = (r == 0.0) || (!s && r <= 2.0 ** w - 1.0);
        else   ok = s ? (r <= 2.0 ** (w - 1)) : (r <= 2.0 ** (w - 1) - 1.0);
        if (!ok) begin
            nv  = 1'b1;
            res = u ? (s ? 64'd0 : mask) : (s ? (64'd1 << (w - 1)) : (mask >> 1));
        end else begin
            ri  = longint'(r);
            res = 64'(s ? -ri : ri) & mask;
            nx  = (fr != 0.0);
        end
    endfunction

    function automatic logic [31:0] rnd_op(input int w);
        logic [7:0]  e;
        logic [22:0] mn;
        int          k;
        k  = int'($urandom_range(0, 15));
        mn = 23'($urandom);
        if (k == 0)      e = 8'hFF;
        else if (k == 1) e = 8'h00;
        else             e = 8'($urandom_range(110, 127 + w + 2));
        if (k == 2) mn = '0;
        return {1'($urandom), e, mn};
    endfunction

    // One isolated operation; checks acceptance, latency and tag alignment.
    task automatic conv(input bit b16, input logic [31:0] a, input logic [2:0] m, input bit u,
                        output logic [63:0] res, output bit onv, output bit onx);
        int         n;
        logic [4:0] tag;
        tag = 5'(tagc);
        tagc++;
        @(posedge clk); #1;
        if (b16) begin
            b_in_valid = 1; b_adata = a; b_rm = m; b_uns = u; b_addr = tag; b_flag = tag[0]; b_out_ready = 1;
        end else begin
            a_in_valid = 1; a_adata = a; a_rm = m; a_uns = u; a_addr = tag; a_flag = tag[0]; a_out_ready = 1;
        end
        @(negedge clk);
        check("in_ready", 64'(b16 ? b_in_ready : a_in_ready), 64'd1);
        @(posedge clk); #1;
        a_in_valid = 0;
        b_in_valid = 0;
        a_rm = 3'($urandom); a_uns = 1'($urandom);
        b_rm = 3'($urandom); b_uns = 1'($urandom);
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (b16 ? b_out_valid : a_out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        check(b16 ? "latency16" : "latency32", 64'(n), b16 ? 64'd1 : 64'd2);
        check("address_out", 64'(b16 ? b_addr_out : a_addr_out), 64'(tag));
        check("flag_out", 64'(b16 ? b_flag_out : a_flag_out), 64'(tag[0]));
        res = b16 ? 64'(b_result) : 64'(a_result);
        onv = b16 ? b_nv : a_nv;
        onx = b16 ? b_nx : a_nx;
    endtask

    task automatic dir(input string nm, input bit b16, input logic [31:0] a, input logic [2:0] m,
                       input bit u, input logic [63:0] er, input bit env, input bit enx);
        logic [63:0] r;
        bit          v, x;
        conv(b16, a, m, u, r, v, x);
        check({nm, ".res"}, r, er);
        check({nm, ".nv"}, 64'(v), 64'(env));
        check({nm, ".nx"}, 64'(x), 64'(enx));
    endtask

    initial begin
        logic [63:0] r, er;
        bit          v, x, ev, ex2;
        logic [31:0] op;
        logic [2:0]  m;
        bit          u, b16;
        logic [31:0] ops [16];
        exp_t        q [$];
        exp_t        e;
        int          idx, got, cyc;
        bit          stalled;
        logic [31:0] p_res;
        bit          p_nv, p_nx;
        logic [4:0]  p_addr;

        rst = 1;
        a_in_valid = 0; a_adata = 0; a_rm = 0; a_uns = 0; a_flag = 0; a_addr = 0; a_out_ready = 0;
        b_in_valid = 0; b_adata = 0; b_rm = 0; b_uns = 0; b_flag = 0; b_addr = 0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid32", 64'(a_out_valid), 64'd0);
        check("rst.result32", 64'(a_result), 64'd0);
        check("rst.flags32", 64'({a_nv, a_nx, a_flag_out}), 64'd0);
        check("rst.addr32", 64'(a_addr_out), 64'd0);
        check("rst.in_ready32", 64'(a_in_ready), 64'd0);
        check("rst.out_valid16", 64'(b_out_valid), 64'd0);
        check("rst.in_ready16", 64'(b_in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 0;

        // Rounding modes on +/-2.5, signed 32-bit
        dir("t1.rne", 0, 32'h40200000, 3'd0, 0, 64'd2, 0, 1);
        dir("t1.rtz", 0, 32'h40200000, 3'd1, 0, 64'd2, 0, 1);
        dir("t1.rdn", 0, 32'h40200000, 3'd2, 0, 64'd2, 0, 1);
        dir("t1.rup", 0, 32'h40200000, 3'd3, 0, 64'd3, 0, 1);
        dir("t1.rmm", 0, 32'h40200000, 3'd4, 0, 64'd3, 0, 1);
        dir("t1b.rne", 0, 32'hC0200000, 3'd0, 0, 64'hFFFFFFFE, 0, 1);
        dir("t1b.rtz", 0, 32'hC0200000, 3'd1, 0, 64'hFFFFFFFE, 0, 1);
        dir("t1b.rdn", 0, 32'hC0200000, 3'd2, 0, 64'hFFFFFFFD, 0, 1);
        dir("t1b.rup", 0, 32'hC0200000, 3'd3, 0, 64'hFFFFFFFE, 0, 1);
        dir("t1b.rmm", 0, 32'hC0200000, 3'd7, 0, 64'hFFFFFFFD, 0, 1);
        dir("t2.pos2p31", 0, 32'h4F000000, 3'd0, 0, 64'h7FFFFFFF, 1, 0);
        dir("t2.neg2p31", 0, 32'hCF000000, 3'd0, 0, 64'h80000000, 0, 0);
        dir("t2.nan", 0, 32'h7FC00000, 3'd0, 0, 64'h7FFFFFFF, 1, 0);
        dir("t2.neginf", 0, 32'hFF800000, 3'd0, 0, 64'h80000000, 1, 0);
        dir("t2b.u2p31", 0, 32'h4F000000, 3'd0, 1, 64'h80000000, 0, 0);
        dir("t3.uneg03", 0, 32'hBE99999A, 3'd0, 1, 64'd0, 0, 1);
        dir("t3.uneg1", 0, 32'hBF800000, 3'd0, 1, 64'd0, 1, 0);
        dir("t3.u2p32", 0, 32'h4F800000, 3'd0, 1, 64'hFFFFFFFF, 1, 0);
        dir("t6.40000", 1, 32'h471C4000, 3'd0, 0, 64'h7FFF, 1, 0);
        dir("t6.half_rne", 1, 32'h3F000000, 3'd0, 0, 64'd0, 0, 1);
        dir("t6.half_rmm", 1, 32'h3F000000, 3'd4, 0, 64'd1, 0, 1);
        dir("t6.subn_rup", 1, 32'h00000001, 3'd3, 0, 64'd0, 0, 0);

        // Random isolated operations on both widths against the reference model
        for (int i = 0; i < 40; i++) begin
            b16 = 1'(i);
            op  = rnd_op(b16 ? 16 : 32);
            m   = 3'($urandom);
            u   = 1'($urandom);
            model(op, m, u, b16 ? 16 : 32, er, ev, ex2);
            conv(b16, op, m, u, r, v, x);
            check($sformatf("rnd%0d.res(op=%h rm=%0d u=%0d)", i, op, m, u), r, er);
            check($sformatf("rnd%0d.nv", i), 64'(v), 64'(ev));
            check($sformatf("rnd%0d.nx", i), 64'(x), 64'(ex2));
        end

        // Streaming with random backpressure; mode inputs change every cycle
        for (int i = 0; i < 16; i++) ops[i] = rnd_op(32);
        idx = 0; got = 0; cyc = 0; stalled = 0;
        p_res = 0; p_nv = 0; p_nx = 0; p_addr = 0;
        @(posedge clk); #1;
        a_in_valid = 1; a_adata = ops[0]; a_addr = 0;
        a_rm = 3'($urandom); a_uns = 1'($urandom); a_flag = 1'($urandom);
        a_out_ready = 1'($urandom);
        while (got < 16 && cyc < 400) begin
            @(negedge clk);
            if (stalled) begin
                check("t4.hold_valid", 64'(a_out_valid), 64'd1);
                check("t4.hold_result", 64'(a_result), 64'(p_res));
                check("t4.hold_flags", 64'({a_nv, a_nx}), 64'({p_nv, p_nx}));
                check("t4.hold_addr", 64'(a_addr_out), 64'(p_addr));
            end
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) begin
                    check("t4.unexpected_output", 64'(a_addr_out), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    check($sformatf("t4.res[%0d]", e.addr), 64'(a_result), e.res);
                    check($sformatf("t4.nv[%0d]", e.addr), 64'(a_nv), 64'(e.nv));
                    check($sformatf("t4.nx[%0d]", e.addr), 64'(a_nx), 64'(e.nx));
                    check($sformatf("t4.flag[%0d]", e.addr), 64'(a_flag_out), 64'(e.flag));
                    check("t4.addr", 64'(a_addr_out), 64'(e.addr));
                end
                got++;
            end
            stalled = a_out_valid && !a_out_ready;
            p_res = a_result; p_nv = a_nv; p_nx = a_nx; p_addr = a_addr_out;
            if (a_in_valid && a_in_ready) begin
                model(a_adata, a_rm, a_uns, 32, e.res, e.nv, e.nx);
                e.flag = a_flag;
                e.addr = a_addr;
                q.push_back(e);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
            if (idx < 16) begin
                a_adata = ops[idx]; a_addr = 5'(idx);
                a_rm = 3'($urandom); a_uns = 1'($urandom); a_flag = 1'($urandom);
            end else begin
                a_in_valid = 0;
            end
            a_out_ready = 1'($urandom);
        end
        check("t4.count", 64'(got), 64'd16);
        a_in_valid = 0;
        a_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;

        // Reset with two operations stalled in flight
        a_out_ready = 0;
        a_in_valid = 1; a_adata = 32'h40400000; a_addr = 5'd21; a_flag = 1; a_rm = 0; a_uns = 0;
        @(posedge clk); #1;
        a_adata = 32'h40800000; a_addr = 5'd22;
        @(posedge clk); #1;
        a_in_valid = 0;
        rst = 1;
        @(negedge clk);
        check("t5.in_ready_in_rst", 64'(a_in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        a_out_ready = 1;
        @(negedge clk);
        check("t5.out_valid", 64'(a_out_valid), 64'd0);
        check("t5.result", 64'(a_result), 64'd0);
        check("t5.flags", 64'({a_nv, a_nx}), 64'd0);
        check("t5.addr", 64'(a_addr_out), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5.no_ghost", 64'(a_out_valid), 64'd0);
        end
        dir("t5.after_rst", 0, 32'h41200000, 3'd0, 0, 64'd10, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
